// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-requester ALU arbiter:
// opcode encodings, flag layout and the arbiter FSM state type.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_INC  = 4'd2;
    localparam logic [OP_W-1:0] OP_DEC  = 4'd3;
    localparam logic [OP_W-1:0] OP_AND  = 4'd4;
    localparam logic [OP_W-1:0] OP_OR   = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd7;
    localparam logic [OP_W-1:0] OP_SHL  = 4'd8;
    localparam logic [OP_W-1:0] OP_SHR  = 4'd9;
    localparam logic [OP_W-1:0] OP_ROL  = 4'd10;
    localparam logic [OP_W-1:0] OP_ROR  = 4'd11;
    localparam logic [OP_W-1:0] OP_LAST = 4'd11;

    // Flag bundle, packed MSB-first as {zero, carry, overflow, sign}.
    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic sign;
    } flags_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

endpackage

// File: rtl/alu.sv
// 8-bit combinational ALU shared by all requesters.
// Carry is carry-out for ADD/INC, borrow for SUB/DEC and the bit shifted
// or rotated out for the shift/rotate group; logic ops clear carry and
// overflow. Opcodes above OP_LAST flag err and force result/flags to zero.
module alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags,
    output logic              err
);

    logic [DATA_W:0] wide;
    logic            carry;
    logic            ovf;
    flags_t          fl;

    // Evaluate the selected operation and derive the flag bundle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        err    = (op > OP_LAST);
        unique case (op)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
                ovf    = (a[7] == b[7]) && (result[7] != a[7]);
            end
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
                ovf    = (a[7] != b[7]) && (result[7] != a[7]);
            end
            OP_INC: begin
                wide   = {1'b0, a} + 9'd1;
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
                ovf    = (a == 8'h7F);
            end
            OP_DEC: begin
                wide   = {1'b0, a} - 9'd1;
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
                ovf    = (a == 8'h80);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[6:0], 1'b0};
                carry  = a[7];
            end
            OP_SHR: begin
                result = {1'b0, a[7:1]};
                carry  = a[0];
            end
            OP_ROL: begin
                result = {a[6:0], a[7]};
                carry  = a[7];
            end
            OP_ROR: begin
                result = {a[0], a[7:1]};
                carry  = a[0];
            end
            default: result = '0;
        endcase

        fl.zero     = (result == '0);
        fl.carry    = carry;
        fl.overflow = ovf;
        fl.sign     = result[7];
        flags       = err ? 4'b0000 : fl;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter letting two requesters share one ALU.
// One transaction in flight: IDLE accepts a request, EXEC registers the ALU
// output, RESP holds the response until the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [OP_W*NUM_REQ-1:0]   req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic [3:0]                rsp_flags,
    output logic                      rsp_err
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]        rsp_flags_q, rsp_flags_d;
    logic              rsp_err_q, rsp_err_d;

    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    logic              grant_id;
    logic              handshake;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;
    logic              alu_err;

    // Round-robin pick: on contention favour the requester not served last.
    always_comb begin
        grant_id  = (req_valid[0] && req_valid[1]) ? ~last_grant_q : ~req_valid[0];
        req_ready = '0;
        if (rst_n && (state_q == ST_IDLE) && (|req_valid)) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign handshake = |(req_valid & req_ready);

    alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .flags  (alu_flags),
        .err    (alu_err)
    );

    // Next-state and response-register computation for the control FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    last_grant_d = grant_id;
                    rsp_id_d     = grant_id;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flags;
                rsp_err_d    = alu_err;
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Operand capture on an accepted request; isolates the ALU from later req_* changes.
    always_ff @(posedge clk) begin
        // NOTE: operand registers carry no reset; they are always written before EXEC reads them.
        if (handshake) begin
            op_q <= grant_id ? req_op[7:4]  : req_op[3:0];
            a_q  <= grant_id ? req_a[15:8]  : req_a[7:0];
            b_q  <= grant_id ? req_b[15:8]  : req_b[7:0];
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset values, arbitration order, latency,
// back-pressure, illegal opcodes, opcode-range edges and reset mid-response.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [7:0]  rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;

    int vectors     = 0;
    int miscompares = 0;

    alu_arbiter #(.NUM_REQ(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3:0] = op;
        req_a[7:0]  = a;
        req_b[7:0]  = b;
    endtask

    task automatic set_req1(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[7:4] = op;
        req_a[15:8] = a;
        req_b[15:8] = b;
    endtask

    // Step cycles until rsp_valid is seen, up to a bound; reports the cycles waited.
    task automatic wait_rsp(output bit seen, output int waited);
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                return;
            end
            tick();
            waited++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        set_req0(OP_ADD, 8'h01, 8'h02);
        set_req1(OP_ADD, 8'h03, 8'h04);
        tick();
        tick();
        #1;
        vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
        vectors++; if (rsp_result !== 8'h00) begin miscompares++; $display("FAIL reset_rsp_result: got %h want 00", rsp_result); end
        vectors++; if (rsp_flags !== 4'b0000) begin miscompares++; $display("FAIL reset_rsp_flags: got %b want 0000", rsp_flags); end
        vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    endtask

    // Both valid on the first cycle out of reset: requester 0 must win first.
    task automatic test_both_after_reset();
        set_req0(OP_INC, 8'hFF, 8'h00);
        set_req1(OP_AND, 8'hF0, 8'h0F);
        req_valid = 2'b11;
        tick();
        rst_n = 1'b1;
        #1;
        vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL first_grant: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b10;
        #1;
        vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL exec_ready: got %b want 00", req_ready); end
        tick();
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL inc_rsp_valid: got %b want 1", rsp_valid); end
        vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL inc_id: got %b want 0", rsp_id); end
        vectors++; if (rsp_result !== 8'h00) begin miscompares++; $display("FAIL inc_result: got %h want 00", rsp_result); end
        vectors++; if (rsp_flags !== 4'b1100) begin miscompares++; $display("FAIL inc_flags: got %b want 1100", rsp_flags); end
        tick();
        #1;
        vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL second_grant: got %b want 10", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL and_rsp_valid: got %b want 1", rsp_valid); end
        vectors++; if (rsp_id !== 1'b1) begin miscompares++; $display("FAIL and_id: got %b want 1", rsp_id); end
        vectors++; if (rsp_result !== 8'h00) begin miscompares++; $display("FAIL and_result: got %h want 00", rsp_result); end
        vectors++; if (rsp_flags !== 4'b1000) begin miscompares++; $display("FAIL and_flags: got %b want 1000", rsp_flags); end
        tick();
    endtask

    // Both held valid: ids alternate and a new response arrives every 3 cycles.
    task automatic test_round_robin();
        bit         seen;
        int         waited;
        logic       exp_id;
        logic [7:0] exp_res;
        set_req0(OP_ADD, 8'h10, 8'h01);
        set_req1(OP_SUB, 8'h20, 8'h01);
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        for (int t = 0; t < 6; t++) begin
            exp_id  = (t % 2 == 1);
            exp_res = exp_id ? 8'h1F : 8'h11;
            wait_rsp(seen, waited);
            vectors++; if (!seen) begin miscompares++; $display("FAIL rr_timeout: txn %0d got no rsp_valid, want rsp_valid=1", t); end
            vectors++; if (rsp_id !== exp_id) begin miscompares++; $display("FAIL rr_id: txn %0d got %b want %b", t, rsp_id, exp_id); end
            vectors++; if (rsp_result !== exp_res) begin miscompares++; $display("FAIL rr_result: txn %0d got %h want %h", t, rsp_result, exp_res); end
            if (t > 0) begin
                vectors++; if (waited !== 2) begin miscompares++; $display("FAIL rr_throughput: txn %0d got %0d want 2", t, waited); end
            end
            tick();
        end
        req_valid = 2'b00;
    endtask

    // Single requester ADD: response two cycles after presentation; later req changes ignored.
    task automatic test_single_add();
        tick();
        set_req0(OP_ADD, 8'd15, 8'd10);
        req_valid = 2'b01;
        #1;
        vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL add_ready: got %b want 01", req_ready); end
        tick();
        set_req0(OP_SUB, 8'hEE, 8'h77);
        req_valid = 2'b00;
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_early_valid: got %b want 0", rsp_valid); end
        tick();
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL add_latency: got %b want 1", rsp_valid); end
        vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL add_id: got %b want 0", rsp_id); end
        vectors++; if (rsp_result !== 8'd25) begin miscompares++; $display("FAIL add_result: got %h want 19", rsp_result); end
        vectors++; if (rsp_flags !== 4'b0000) begin miscompares++; $display("FAIL add_flags: got %b want 0000", rsp_flags); end
        vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL add_err: got %b want 0", rsp_err); end
        tick();
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_done: got %b want 0", rsp_valid); end
    endtask

    // Consumer stalls for 3 cycles: response holds and no new request is accepted.
    task automatic test_stall();
        bit seen;
        int waited;
        rsp_ready = 1'b0;
        set_req0(OP_XOR, 8'h3C, 8'hFF);
        set_req1(OP_ADD, 8'h01, 8'h01);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b11;
        wait_rsp(seen, waited);
        vectors++; if (!seen) begin miscompares++; $display("FAIL stall_timeout: got no rsp_valid, want rsp_valid=1"); end
        for (int k = 0; k < 3; k++) begin
            vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid: cycle %0d got %b want 1", k, rsp_valid); end
            vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL stall_id: cycle %0d got %b want 0", k, rsp_id); end
            vectors++; if (rsp_result !== 8'hC3) begin miscompares++; $display("FAIL stall_result: cycle %0d got %h want c3", k, rsp_result); end
            vectors++; if (rsp_flags !== 4'b0001) begin miscompares++; $display("FAIL stall_flags: cycle %0d got %b want 0001", k, rsp_flags); end
            vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL stall_err: cycle %0d got %b want 0", k, rsp_err); end
            vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL stall_ready: cycle %0d got %b want 00", k, req_ready); end
            tick();
        end
        vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL stall_hold: got %b want 1", rsp_valid); end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        tick();
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release: got %b want 0", rsp_valid); end
    endtask

    // Illegal opcode from requester 1 completes with err set and zeroed data.
    task automatic test_illegal();
        bit seen;
        int waited;
        set_req1(4'hD, 8'h55, 8'hAA);
        req_valid = 2'b10;
        #1;
        vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL ill_ready: got %b want 10", req_ready); end
        tick();
        set_req1(OP_ADD, 8'h01, 8'h01);
        req_valid = 2'b00;
        wait_rsp(seen, waited);
        vectors++; if (!seen) begin miscompares++; $display("FAIL ill_timeout: got no rsp_valid, want rsp_valid=1"); end
        vectors++; if (rsp_id !== 1'b1) begin miscompares++; $display("FAIL ill_id: got %b want 1", rsp_id); end
        vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("FAIL ill_err: got %b want 1", rsp_err); end
        vectors++; if (rsp_result !== 8'h00) begin miscompares++; $display("FAIL ill_result: got %h want 00", rsp_result); end
        vectors++; if (rsp_flags !== 4'b0000) begin miscompares++; $display("FAIL ill_flags: got %b want 0000", rsp_flags); end
        tick();
    endtask

    // Opcode edges: last legal op, first illegal op and borrow/overflow corners.
    task automatic test_op_boundary();
        bit         seen;
        int         waited;
        logic [3:0] t_op  [4] = '{OP_ROR, 4'hC, OP_DEC, OP_SUB};
        logic [7:0] t_a   [4] = '{8'h01, 8'h12, 8'h00, 8'h80};
        logic [7:0] t_b   [4] = '{8'h00, 8'h34, 8'h00, 8'h01};
        logic [7:0] t_res [4] = '{8'h80, 8'h00, 8'hFF, 8'h7F};
        logic [3:0] t_fl  [4] = '{4'b0101, 4'b0000, 4'b0101, 4'b0010};
        logic       t_err [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            set_req0(t_op[i], t_a[i], t_b[i]);
            req_valid = 2'b01;
            tick();
            req_valid = 2'b00;
            wait_rsp(seen, waited);
            vectors++; if (!seen) begin miscompares++; $display("FAIL op_timeout: vec %0d got no rsp_valid, want rsp_valid=1", i); end
            vectors++; if (rsp_result !== t_res[i]) begin miscompares++; $display("FAIL op_result: vec %0d got %h want %h", i, rsp_result, t_res[i]); end
            vectors++; if (rsp_flags !== t_fl[i]) begin miscompares++; $display("FAIL op_flags: vec %0d got %b want %b", i, rsp_flags, t_fl[i]); end
            vectors++; if (rsp_err !== t_err[i]) begin miscompares++; $display("FAIL op_err: vec %0d got %b want %b", i, rsp_err, t_err[i]); end
            tick();
        end
    endtask

    // Reset while a response waits: it is dropped and the block restarts cleanly.
    task automatic test_reset_in_resp();
        bit seen;
        int waited;
        rsp_ready = 1'b0;
        set_req1(OP_ADD, 8'h01, 8'h01);
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        wait_rsp(seen, waited);
        vectors++; if (!seen) begin miscompares++; $display("FAIL rir_timeout: got no rsp_valid, want rsp_valid=1"); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rir_valid: got %b want 0", rsp_valid); end
        vectors++; if (rsp_result !== 8'h00) begin miscompares++; $display("FAIL rir_result: got %h want 00", rsp_result); end
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rir_pulse: cycle %0d got %b want 0", k, rsp_valid); end
        end
        set_req0(OP_OR, 8'hF0, 8'h0F);
        req_valid = 2'b01;
        #1;
        vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rir_ready: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        wait_rsp(seen, waited);
        vectors++; if (!seen) begin miscompares++; $display("FAIL or_timeout: got no rsp_valid, want rsp_valid=1"); end
        vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL or_id: got %b want 0", rsp_id); end
        vectors++; if (rsp_result !== 8'hFF) begin miscompares++; $display("FAIL or_result: got %h want ff", rsp_result); end
        vectors++; if (rsp_flags !== 4'b0001) begin miscompares++; $display("FAIL or_flags: got %b want 0001", rsp_flags); end
        tick();
    endtask

    initial begin
        test_reset();
        test_both_after_reset();
        test_round_robin();
        test_single_add();
        test_stall();
        test_illegal();
        test_op_boundary();
        test_reset_in_resp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
